// File: rtl/bt_native_clock_gen.sv
// Bluetooth native clock / slot timing generator: 1 us strobe -> slot and half-slot pulses,
// CLKN (LSB = half-slot), per-piconet offset clocks, and windowed access-code resync.

module bt_pico_lane #(
  parameter int CLK_W = 28
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic [CLK_W-1:0] i_base,
  input  logic [CLK_W-1:0] i_ofs,
  output logic [CLK_W-1:0] o_clk
);
  logic [CLK_W-1:0] r_clk;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) r_clk <= '0;
    else         r_clk <= i_base + i_ofs;
  end

  assign o_clk = r_clk;
endmodule

module bt_native_clock_gen #(
  parameter int CLK_W       = 28,
  parameter int CNT_W       = 10,
  parameter int SLOT_US     = 625,
  parameter int SYNC_OFS_US = 68,
  parameter int SYNC_WIN    = 10,
  parameter int NUM_PICO    = 2
) (
  input  logic                      clk_6M,
  input  logic                      rstz,
  input  logic                      p_1us,
  input  logic                      regi_clk_en,
  input  logic                      regi_clkn_load,
  input  logic [CLK_W-1:0]          regi_clkn_value,
  input  logic [NUM_PICO*CLK_W-1:0] regi_clk_offset,
  input  logic [CNT_W-1:0]          regi_pre_us,
  input  logic                      corre_sync_p,
  output logic [CLK_W-1:0]          CLKN,
  output logic [NUM_PICO*CLK_W-1:0] pico_clk,
  output logic [CNT_W-1:0]          counter_1us,
  output logic                      tslot_p,
  output logic                      half_tslot_p,
  output logic                      pre_tslot_p,
  output logic                      sync_accept_p,
  output logic                      sync_reject_p,
  output logic [CNT_W:0]            sync_drift
);
  localparam int HALF_IDX = SLOT_US / 2;

  localparam logic [CNT_W-1:0]        C_LAST  = CNT_W'(SLOT_US - 1);
  localparam logic [CNT_W-1:0]        C_HALF  = CNT_W'(HALF_IDX - 1);
  localparam logic [CNT_W:0]          C_SLOT  = (CNT_W+1)'(SLOT_US);
  localparam logic [CNT_W-1:0]        C_OFS   = CNT_W'(SYNC_OFS_US);
  localparam logic signed [CNT_W:0]   C_OFS_S = (CNT_W+1)'(SYNC_OFS_US);
  localparam logic signed [CNT_W:0]   C_WIN   = (CNT_W+1)'(SYNC_WIN);

  // The window must sit strictly inside the first half-slot so an accepted
  // sync can never collide with a half-slot or slot tick.
  if (SYNC_OFS_US - SYNC_WIN < 0) begin : g_bad_win_lo
    $error("sync window extends below counter 0");
  end
  if (SYNC_OFS_US + SYNC_WIN >= HALF_IDX - 1) begin : g_bad_win_hi
    $error("sync window reaches the half-slot tick");
  end

  logic [CLK_W-1:0]        r_clkn;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W:0]          r_drift;

  logic                    w_run, w_tick, w_tslot, w_half, w_pre;
  logic                    w_inwin, w_acc, w_rej;
  logic signed [CNT_W:0]   w_diff;
  logic [CLK_W-1:0]        w_clkn_next;
  logic [CNT_W-1:0]        w_cnt_next;
  logic [CNT_W:0]          w_drift_next;
  logic [NUM_PICO-1:0][CLK_W-1:0] w_pico;

  // A load cycle swallows the tick and any sync; reset swallows every pulse.
  assign w_run   = rstz & regi_clk_en & ~regi_clkn_load;
  assign w_tick  = w_run & p_1us;
  assign w_tslot = w_tick & (r_cnt == C_LAST);
  assign w_half  = w_tick & (r_cnt == C_HALF);
  assign w_pre   = w_tick & ({1'b0, regi_pre_us} < C_SLOT) & (r_cnt == C_LAST - regi_pre_us);

  assign w_diff  = $signed({1'b0, r_cnt}) - C_OFS_S;
  assign w_inwin = (w_diff >= -C_WIN) && (w_diff <= C_WIN);
  assign w_acc   = w_run & corre_sync_p & w_inwin;
  assign w_rej   = w_run & corre_sync_p & ~w_inwin;

  always_comb begin
    w_clkn_next  = r_clkn;
    w_cnt_next   = r_cnt;
    w_drift_next = r_drift;
    if (regi_clkn_load) begin
      w_clkn_next = regi_clkn_value;
      w_cnt_next  = '0;
    end else if (regi_clk_en) begin
      if (w_acc) begin
        w_cnt_next   = C_OFS;
        w_drift_next = -w_diff;
      end else if (w_tslot) begin
        w_cnt_next  = '0;
        w_clkn_next = r_clkn + 1'b1;
      end else if (w_half) begin
        w_cnt_next  = r_cnt + 1'b1;
        w_clkn_next = r_clkn + 1'b1;
      end else if (w_tick) begin
        w_cnt_next  = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      r_clkn  <= '0;
      r_cnt   <= '0;
      r_drift <= '0;
    end else begin
      r_clkn  <= w_clkn_next;
      r_cnt   <= w_cnt_next;
      r_drift <= w_drift_next;
    end
  end

  // Piconet clocks follow the post-edge CLKN, so they never lag it.
  for (genvar i = 0; i < NUM_PICO; i++) begin : g_pico
    bt_pico_lane #(.CLK_W(CLK_W)) u_lane (
      .gclk   (clk_6M),
      .grst_n (rstz),
      .i_base (w_clkn_next),
      .i_ofs  (regi_clk_offset[i*CLK_W +: CLK_W]),
      .o_clk  (w_pico[i])
    );
  end

  assign pico_clk      = w_pico;
  assign CLKN          = r_clkn;
  assign counter_1us   = r_cnt;
  assign sync_drift    = r_drift;
  assign tslot_p       = w_tslot;
  assign half_tslot_p  = w_half;
  assign pre_tslot_p   = w_pre;
  assign sync_accept_p = w_acc;
  assign sync_reject_p = w_rej;
endmodule

// File: tb/tb_bt_native_clock_gen.sv
// Bench for bt_native_clock_gen: slot-level reference model checked every cycle,
// plus directed scenarios with hand-computed values.

module tb_bt_native_clock_gen;
  localparam int CLK_W = 28;
  localparam int CNT_W = 10;
  localparam int NP    = 2;
  localparam int SLOT  = 625;
  localparam int OFS   = 68;
  localparam int WIN   = 10;

  logic                   clk_6M = 1'b0;
  logic                   rstz = 1'b0;
  logic                   p_1us = 1'b0;
  logic                   regi_clk_en = 1'b0;
  logic                   regi_clkn_load = 1'b0;
  logic [CLK_W-1:0]       regi_clkn_value = '0;
  logic [NP*CLK_W-1:0]    regi_clk_offset = '0;
  logic [CNT_W-1:0]       regi_pre_us = '0;
  logic                   corre_sync_p = 1'b0;
  logic [CLK_W-1:0]       CLKN;
  logic [NP*CLK_W-1:0]    pico_clk;
  logic [CNT_W-1:0]       counter_1us;
  logic                   tslot_p, half_tslot_p, pre_tslot_p, sync_accept_p, sync_reject_p;
  logic [CNT_W:0]         sync_drift;

  bt_native_clock_gen dut (
    .clk_6M(clk_6M), .rstz(rstz), .p_1us(p_1us), .regi_clk_en(regi_clk_en),
    .regi_clkn_load(regi_clkn_load), .regi_clkn_value(regi_clkn_value),
    .regi_clk_offset(regi_clk_offset), .regi_pre_us(regi_pre_us),
    .corre_sync_p(corre_sync_p), .CLKN(CLKN), .pico_clk(pico_clk),
    .counter_1us(counter_1us), .tslot_p(tslot_p), .half_tslot_p(half_tslot_p),
    .pre_tslot_p(pre_tslot_p), .sync_accept_p(sync_accept_p),
    .sync_reject_p(sync_reject_p), .sync_drift(sync_drift)
  );

  always #5 clk_6M = ~clk_6M;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: slot position as an integer, CLKN advanced whenever the
  // position crosses the middle or the end of a slot.
  int               m_cnt = 0;
  int               m_drift = 0;
  logic [CLK_W-1:0] m_clkn = '0;
  logic [CLK_W-1:0] m_pico [NP];

  function automatic bit in_win(input int c);
    return (c - OFS <= WIN) && (OFS - c <= WIN);
  endfunction

  always @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      m_cnt = 0;
      m_clkn = '0;
      m_drift = 0;
      for (int i = 0; i < NP; i++) m_pico[i] = '0;
    end else begin
      int nc;
      logic [CLK_W-1:0] nk;
      nc = m_cnt;
      nk = m_clkn;
      if (regi_clkn_load) begin
        nk = regi_clkn_value;
        nc = 0;
      end else if (regi_clk_en) begin
        if (corre_sync_p && in_win(m_cnt)) begin
          m_drift = OFS - m_cnt;
          nc = OFS;
        end else if (p_1us) begin
          nc = (m_cnt + 1) % SLOT;
          if (m_cnt == SLOT - 1 || m_cnt == SLOT / 2 - 1) nk = m_clkn + 1;
        end
      end
      for (int i = 0; i < NP; i++) m_pico[i] = nk + regi_clk_offset[i*CLK_W +: CLK_W];
      m_cnt = nc;
      m_clkn = nk;
    end
  end

  // Per-cycle compare plus pulse bookkeeping for the directed checks.
  bit e_run;
  int c_tslot = 0, c_half = 0, c_pre = 0, c_acc = 0, c_rej = 0;
  int us_ctr = 0, pre_us_at = 0, tslot_us_at = 0, pre_cnt_at = 0;
  logic [CNT_W:0] e_drift;

  always @(negedge clk_6M) begin
    e_run = rstz && regi_clk_en && !regi_clkn_load;
    e_drift = m_drift[CNT_W:0];
    chk("CLKN", 64'(CLKN), 64'(m_clkn));
    chk("counter_1us", 64'(counter_1us), 64'(m_cnt));
    chk("sync_drift", 64'(sync_drift), 64'(e_drift));
    for (int i = 0; i < NP; i++) chk("pico_clk", 64'(pico_clk[i*CLK_W +: CLK_W]), 64'(m_pico[i]));
    chk("tslot_p", 64'(tslot_p), 64'(e_run && p_1us && m_cnt == SLOT - 1));
    chk("half_tslot_p", 64'(half_tslot_p), 64'(e_run && p_1us && m_cnt == SLOT / 2 - 1));
    chk("pre_tslot_p", 64'(pre_tslot_p), 64'(e_run && p_1us && (SLOT - 1 - m_cnt) == int'(regi_pre_us)));
    chk("sync_accept_p", 64'(sync_accept_p), 64'(e_run && corre_sync_p && in_win(m_cnt)));
    chk("sync_reject_p", 64'(sync_reject_p), 64'(e_run && corre_sync_p && !in_win(m_cnt)));
    if (e_run && p_1us) us_ctr++;
    if (tslot_p) begin c_tslot++; tslot_us_at = us_ctr; end
    if (half_tslot_p) c_half++;
    if (pre_tslot_p) begin c_pre++; pre_us_at = us_ctr; pre_cnt_at = int'(counter_1us); end
    if (sync_accept_p) c_acc++;
    if (sync_reject_p) c_rej++;
  end

  task automatic cyc();
    @(posedge clk_6M);
    #1;
    p_1us = 1'b0;
    corre_sync_p = 1'b0;
    regi_clkn_load = 1'b0;
  endtask

  task automatic strobe();
    p_1us = 1'b1;
    cyc(); cyc(); cyc();
  endtask

  task automatic run_us(input int n);
    repeat (n) strobe();
  endtask

  task automatic run_to(input int t);
    int k = 0;
    while (m_cnt != t && k < 2000) begin
      strobe();
      k++;
    end
    if (k >= 2000) begin
      n_chk++;
      n_err++;
      $display("FAIL run_to: position %0d never reached", t);
    end
  endtask

  initial begin
    regi_clk_offset = {28'hFFFFFFF, 28'h0000010};
    regi_pre_us = 10'd700;
    repeat (3) @(posedge clk_6M);
    #1;
    chk("reset CLKN", 64'(CLKN), 64'h0);
    chk("reset counter", 64'(counter_1us), 64'h0);
    chk("reset drift", 64'(sync_drift), 64'h0);
    chk("reset pico", 64'(pico_clk), 64'h0);
    rstz = 1'b1;
    regi_clk_en = 1'b1;

    // T1: three slots from reset
    run_us(312);
    chk("T1 CLKN half", 64'(CLKN), 64'd1);
    chk("T1 counter half", 64'(counter_1us), 64'd312);
    run_us(313);
    chk("T1 CLKN slot1", 64'(CLKN), 64'd2);
    chk("T1 counter slot1", 64'(counter_1us), 64'd0);
    run_us(1250);
    chk("T1 CLKN slot3", 64'(CLKN), 64'd6);
    chk("T1 tslot count", 64'(c_tslot), 64'd3);
    chk("T1 half count", 64'(c_half), 64'd3);
    chk("T1 tslot us", 64'(tslot_us_at), 64'd1875);
    chk("T1 pre never", 64'(c_pre), 64'd0);

    // T2: pre-slot lead
    regi_pre_us = 10'd100;
    run_us(625);
    chk("T2 pre count", 64'(c_pre), 64'd1);
    chk("T2 pre counter", 64'(pre_cnt_at), 64'd524);
    chk("T2 pre lead", 64'(tslot_us_at - pre_us_at), 64'd100);
    regi_pre_us = 10'd700;
    run_us(625);
    chk("T2 pre 700", 64'(c_pre), 64'd1);
    regi_pre_us = 10'd0;
    run_us(625);
    chk("T2 pre0 count", 64'(c_pre), 64'd2);
    chk("T2 pre0 counter", 64'(pre_cnt_at), 64'd624);
    chk("T2 pre0 coincide", 64'(pre_us_at), 64'(tslot_us_at));
    chk("T2 CLKN", 64'(CLKN), 64'd12);
    regi_pre_us = 10'd700;

    // T3: accepted syncs, one with a coincident strobe
    run_to(63);
    p_1us = 1'b1; corre_sync_p = 1'b1; cyc();
    chk("T3 counter", 64'(counter_1us), 64'd68);
    chk("T3 drift +5", 64'(sync_drift), 64'h005);
    chk("T3 CLKN held", 64'(CLKN), 64'd12);
    chk("T3 accept count", 64'(c_acc), 64'd1);
    cyc(); cyc();
    run_to(75);
    corre_sync_p = 1'b1; cyc();
    chk("T3 counter b", 64'(counter_1us), 64'd68);
    chk("T3 drift -7", 64'(sync_drift), 64'h7F9);

    // T4: reject and window edges
    run_to(200);
    p_1us = 1'b1; corre_sync_p = 1'b1; cyc();
    chk("T4 counter", 64'(counter_1us), 64'd201);
    chk("T4 reject count", 64'(c_rej), 64'd1);
    chk("T4 drift held", 64'(sync_drift), 64'h7F9);
    run_to(78);
    corre_sync_p = 1'b1; cyc();
    chk("T4 edge 78 drift", 64'(sync_drift), 64'h7F6);
    chk("T4 edge 78 counter", 64'(counter_1us), 64'd68);
    run_to(79);
    corre_sync_p = 1'b1; cyc();
    chk("T4 edge 79 counter", 64'(counter_1us), 64'd79);
    chk("T4 edge 79 reject", 64'(c_rej), 64'd2);
    run_to(57);
    p_1us = 1'b1; corre_sync_p = 1'b1; cyc();
    chk("T4 edge 57 counter", 64'(counter_1us), 64'd58);
    chk("T4 edge 57 reject", 64'(c_rej), 64'd3);
    corre_sync_p = 1'b1; cyc();
    chk("T4 edge 58 drift", 64'(sync_drift), 64'h00A);
    chk("T4 accept count", 64'(c_acc), 64'd4);
    chk("T4 CLKN", 64'(CLKN), 64'd16);

    // T5: load at the slot end, then wrap
    run_to(624);
    p_1us = 1'b1; regi_clkn_load = 1'b1; regi_clkn_value = 28'hFFFFFFF; cyc();
    chk("T5 CLKN load", 64'(CLKN), 64'hFFFFFFF);
    chk("T5 counter load", 64'(counter_1us), 64'd0);
    run_to(312);
    chk("T5 CLKN wrap", 64'(CLKN), 64'h0);
    chk("T6 pico0", 64'(pico_clk[27:0]), 64'h10);
    chk("T6 pico1", 64'(pico_clk[55:28]), 64'hFFFFFFF);
    regi_clk_offset[27:0] = 28'h20; cyc();
    chk("T6 pico0 new ofs", 64'(pico_clk[27:0]), 64'h20);

    // T6: freeze, load while frozen, async reset mid-slot
    regi_clk_en = 1'b0;
    repeat (5) begin p_1us = 1'b1; corre_sync_p = 1'b1; cyc(); end
    chk("T6 frozen counter", 64'(counter_1us), 64'd312);
    chk("T6 frozen CLKN", 64'(CLKN), 64'h0);
    chk("T6 frozen reject", 64'(c_rej), 64'd3);
    regi_clkn_load = 1'b1; regi_clkn_value = 28'h123; cyc();
    chk("T6 load CLKN", 64'(CLKN), 64'h123);
    chk("T6 load counter", 64'(counter_1us), 64'd0);
    chk("T6 load pico0", 64'(pico_clk[27:0]), 64'h143);
    chk("T6 load pico1", 64'(pico_clk[55:28]), 64'h122);
    regi_clk_en = 1'b1;
    run_to(400);
    chk("T6 CLKN pre-reset", 64'(CLKN), 64'h124);
    regi_pre_us = 10'd624;
    @(posedge clk_6M);
    #2;
    rstz = 1'b0;
    p_1us = 1'b1;
    #1;
    chk("T6 rst CLKN", 64'(CLKN), 64'h0);
    chk("T6 rst counter", 64'(counter_1us), 64'h0);
    chk("T6 rst pico", 64'(pico_clk), 64'h0);
    chk("T6 rst drift", 64'(sync_drift), 64'h0);
    chk("T6 rst pre", 64'(pre_tslot_p), 64'h0);
    @(posedge clk_6M);
    #1;
    p_1us = 1'b0;
    rstz = 1'b1;
    run_us(10);
    chk("T6 after rst counter", 64'(counter_1us), 64'd10);
    chk("T6 after rst CLKN", 64'(CLKN), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
